mux8_rr_collector: RTL and testbench
====================================

// Module: mux8_rr_collector
// PURPOSE
//  8-to-1 collector: merges eight 16-bit valid/ready channels into one output stream.
//  Round-robin arbitration with optional burst hold; one registered output stage.
//  out_sel carries the source index so a downstream 1-to-8 demux can re-split the stream.
//  out_sel drives the demux select triple directly: out_sel[2]=MSB select, out_sel[0]=LSB.
// PARAMETERS
//  WIDTH  16  data width per channel
//  BURST  4   max consecutive words granted to one channel (1..15; 1 = pure round-robin)
// PORTS
//  clk        in   1         single clock; all state updates on posedge
//  rst        in   1         synchronous, active-high reset
//  in_data    in   8*WIDTH   channel k occupies bits [WIDTH*k +: WIDTH]
//  in_valid   in   8         channel k holds a word
//  in_ready   out  8         channel k word accepted this cycle (one-hot or zero)
//  out_data   out  WIDTH     registered output word
//  out_sel    out  3         index 0..7 of the channel that produced out_data
//  out_valid  out  1         out_data/out_sel hold a word
//  out_ready  in   1         downstream accepts the word this cycle
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_sel=0, in_ready=0, rr pointer=0, burst count=0,
//   FSM=IDLE. Reset wins over every other event; a word in flight at reset is dropped.
//  load = ~out_valid | out_ready (output register empty or draining this cycle).
//  in_ready[k] = load & grant[k]; grant is combinational from in_valid, pointer and FSM state.
//  Transfer on a channel = in_valid[k] & in_ready[k]; next cycle out_valid=1,
//   out_data=in_data[k], out_sel=k. Latency 1 cycle; throughput 1 word/cycle.
//  If load=0: out_data/out_sel/out_valid hold; in_ready=0; FSM and pointer frozen.
//  If load=1 and no transfer: out_valid becomes 0 (after draining the current word, if any).
//  FSM:
//   IDLE : grant = first k with in_valid[k], searched from pointer upward, wrapping 7->0.
//          On transfer from k: cnt=1; if BURST>1 go HOLD(owner=k), else pointer=k+1 mod 8.
//   HOLD : grant = owner if in_valid[owner]; on transfer cnt=cnt+1.
//          When cnt reaches BURST, or in_valid[owner]=0 with load=1:
//          pointer=owner+1 mod 8, cnt=0, go IDLE. In the in_valid[owner]=0 case the
//          exit is a cycle with no transfer; arbitration resumes in the following cycle.
//  Pointer wrap: owner 7 -> pointer 0.
//  in_valid must not drop without a transfer (source rule); the block does not check it.
//  in_data is sampled only on a transfer.
// STRUCTURE
//  Shared package/header: N_CH=8, SEL_W=3, default WIDTH=16, FSM state encodings
//   (IDLE=0, HOLD=1), channel slice macro.
//  Sub-module rr_arbiter_8: inputs req[7:0], ptr[2:0]; outputs gnt[7:0] one-hot,
//   gnt_idx[2:0], any. Purely combinational, double-width rotate-and-priority search.
//  Top level holds the FSM, pointer, burst counter and output register.
// TESTING
//  1 Reset: hold rst 2 cycles with all in_valid=1
//    -> out_valid=0 and in_ready=0 throughout; first grant after release is ch0.
//  2 All 8 valid, BURST=1, out_ready=1, in_data[k]=16'hA0+k
//    -> out_sel sequence 0,1,...,7,0; out_data 00A0..00A7; one word per cycle.
//  3 BURST=4, ch2 and ch5 continuously valid
//    -> out_sel 2,2,2,2,5,5,5,5,2,...
//  4 Back-pressure: out_ready=0 for 3 cycles while out_valid=1
//    -> out_data/out_sel stable, in_ready=0, no word lost or duplicated.
//  5 Early burst end: BURST=4, ch3 sends 2 words then drops in_valid, ch4 valid
//    -> HOLD exits, next grant is ch4.
//  6 Mid-stream reset: rst asserted while out_valid=1 at out_sel=6
//    -> next cycle out_valid=0, pointer=0; ch0 served first after release.

Source files
------------

// File: rtl/mux8_rr_collector_pkg.sv
// Shared constants, FSM encoding and the channel slice helper for the 8-to-1 collector.
package mux8_rr_collector_pkg;

    localparam int N_CH      = 8;
    localparam int SEL_W     = 3;
    localparam int WIDTH_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Next channel index; the 3-bit add wraps 7 -> 0 on its own.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// Word slice of channel k inside a flat multi-channel bus.
`define MUX8_CH_SLICE(bus, k, w) bus[(w)*(k) +: (w)]

// File: rtl/mux8_rr_collector_rr_arbiter_8.sv
// Combinational round-robin search: the first requester at or above ptr wins,
// wrapping from 7 back to 0.
module rr_arbiter_8
    import mux8_rr_collector_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;

    // Rotating the doubled vector puts channel ptr at bit 0, so the wrap comes for free.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[N_CH-1:0];

    // Lowest set bit of the rotated request wins; undo the rotation on the index.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_idx = ptr + SEL_W'(i);
                any     = 1'b1;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux8_rr_collector.sv
// 8-to-1 valid/ready collector with round-robin arbitration, burst hold and a
// single registered output stage. out_sel tags each word with its source channel.
//
//   state | meaning
//   IDLE  | round-robin search from ptr for the next channel to serve
//   HOLD  | owner keeps the grant until BURST words or it runs dry
module mux8_rr_collector
    import mux8_rr_collector_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [3:0] BURST_CNT = 4'(BURST);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [N_CH-1:0]  arb_gnt;
    logic [SEL_W-1:0] arb_idx;
    logic             arb_any;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] sel_idx;
    logic             load;
    logic             xfer;

    rr_arbiter_8 u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Output register can take a word when empty or draining; reset blocks any accept.
    assign load     = (~out_valid | out_ready) & ~rst;
    assign in_ready = grant & {N_CH{load}};

    // Grant selection and next-state; nothing moves unless the output stage can load.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        grant   = '0;
        sel_idx = arb_idx;
        xfer    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant   = arb_gnt;
                sel_idx = arb_idx;
                if (load && arb_any) begin
                    xfer  = 1'b1;
                    cnt_d = 4'd1;
                    if (BURST > 1) begin
                        state_d = ST_HOLD;
                        owner_d = arb_idx;
                    end else begin
                        ptr_d = next_idx(arb_idx);
                    end
                end
            end
            ST_HOLD: begin
                sel_idx        = owner_q;
                grant[owner_q] = in_valid[owner_q];
                if (load) begin
                    if (in_valid[owner_q]) begin
                        xfer  = 1'b1;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == BURST_CNT) begin
                            ptr_d   = next_idx(owner_q);
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Owner ran dry: spend this cycle leaving, rearbitrate next cycle.
                        ptr_d   = next_idx(owner_q);
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output stage: capture the granted word, or go empty when nothing transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= `MUX8_CH_SLICE(in_data, sel_idx, WIDTH);
                out_sel  <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux8_rr_collector.sv
// Bench: two collectors (BURST=1 and BURST=4) driven by independent random sources,
// checked against a behavioural arbitration model through per-instance scoreboards.
module tb_mux8_rr_collector;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [8*W-1:0] in_data   [2];
    logic [7:0]     in_valid  [2];
    logic [7:0]     in_ready  [2];
    logic [W-1:0]   out_data  [2];
    logic [2:0]     out_sel   [2];
    logic           out_valid [2];
    logic           out_ready [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit rst_req;
    int p_valid;
    int p_ready;
    bit fixed_data;
    int rem [2][8];
    int pend [2];
    int tot [2];

    int m_ptr [2];
    int m_own [2];
    int m_cnt [2];
    bit m_ov  [2];

    logic [18:0] exp0 [$];
    logic [18:0] exp1 [$];
    logic [18:0] obs0 [$];
    logic [18:0] obs1 [$];
    int          obst0 [$];
    int          obst1 [$];
    bit          held   [2];
    logic [18:0] held_v [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mux8_rr_collector #(.WIDTH(W), .BURST(1)) u_b1 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_data(out_data[0]), .out_sel(out_sel[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0])
    );

    mux8_rr_collector #(.WIDTH(W), .BURST(4)) u_b4 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_data(out_data[1]), .out_sel(out_sel[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1])
    );

    function automatic int burst_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", d, name, act, exp, cyc);
        end
    endtask

    function automatic int exp_size(input int d);
        return (d == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic exp_push(input int d, input logic [18:0] v);
        if (d == 0) exp0.push_back(v); else exp1.push_back(v);
    endtask

    function automatic logic [18:0] exp_pop(input int d);
        return (d == 0) ? exp0.pop_front() : exp1.pop_front();
    endfunction

    task automatic exp_flush(input int d);
        if (d == 0) exp0.delete(); else exp1.delete();
    endtask

    task automatic obs_push(input int d, input logic [18:0] v);
        if (d == 0) begin obs0.push_back(v); obst0.push_back(cyc); end
        else begin obs1.push_back(v); obst1.push_back(cyc); end
    endtask

    task automatic obs_clear();
        obs0.delete(); obs1.delete(); obst0.delete(); obst1.delete();
    endtask

    function automatic int obs_size(input int d);
        return (d == 0) ? obs0.size() : obs1.size();
    endfunction

    function automatic logic [18:0] obs_at(input int d, input int i);
        return (d == 0) ? obs0[i] : obs1[i];
    endfunction

    // Reference: who should win this cycle, from the arbitration rules alone.
    task automatic model_step(input int d, output int win);
        bit load;
        int c;
        win = -1;
        if (rst) begin
            m_ptr[d] = 0; m_own[d] = -1; m_cnt[d] = 0; m_ov[d] = 1'b0;
            exp_flush(d);
            return;
        end
        load = !m_ov[d] || out_ready[d];
        if (!load) return;
        if (m_own[d] >= 0) begin
            if (in_valid[d][m_own[d]]) win = m_own[d];
            else begin
                m_ptr[d] = (m_own[d] + 1) % 8; m_own[d] = -1; m_cnt[d] = 0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                c = (m_ptr[d] + i) % 8;
                if (in_valid[d][c]) begin win = c; break; end
            end
        end
        if (win >= 0) begin
            m_own[d] = win;
            m_cnt[d]++;
            if (m_cnt[d] == burst_of(d)) begin
                m_ptr[d] = (win + 1) % 8; m_own[d] = -1; m_cnt[d] = 0;
            end
        end
        m_ov[d] = (win >= 0);
    endtask

    // One clock: retire last transfer at the sources, drive new stimulus, predict.
    task automatic step();
        bit         rst_prev;
        int         win;
        logic [7:0] er;
        @(posedge clk);
        #1;
        rst_prev = rst;
        rst = rst_req;
        for (int d = 0; d < 2; d++) begin
            if (pend[d] >= 0) begin
                in_valid[d][pend[d]] = 1'b0;
                rem[d][pend[d]]--;
                pend[d] = -1;
            end
            if (rst) in_valid[d] = '0;
            for (int k = 0; k < 8; k++) begin
                if (!in_valid[d][k] && rem[d][k] > 0 && $urandom_range(99) < p_valid) begin
                    in_valid[d][k] = 1'b1;
                    in_data[d][W*k +: W] = fixed_data ? W'(16'hA0 + k) : W'($urandom);
                end
            end
            out_ready[d] = ($urandom_range(99) < p_ready);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst_prev)
                check("reset_outputs", d, {12'd0, out_valid[d], out_sel[d], out_data[d]}, 32'd0);
            model_step(d, win);
            er = (win >= 0) ? (8'd1 << win) : 8'd0;
            check("in_ready", d, 32'(in_ready[d]), 32'(er));
            if (win >= 0) begin
                exp_push(d, {3'(win), in_data[d][W*win +: W]});
                pend[d] = win;
            end
        end
    endtask

    // Monitor: every accepted output word is popped from the scoreboard and compared.
    task automatic mon(input int d);
        logic [18:0] cur;
        logic [18:0] e;
        cur = {out_sel[d], out_data[d]};
        if (rst) begin
            held[d] = 1'b0;
            return;
        end
        if (held[d]) check("hold_stable", d, {12'd0, out_valid[d], cur}, {12'd0, 1'b1, held_v[d]});
        held[d]   = out_valid[d] && !out_ready[d];
        held_v[d] = cur;
        if (out_valid[d] && out_ready[d]) begin
            if (exp_size(d) == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut%0d spurious_word: got %0h expected none (cycle %0d)", d, cur, cyc);
            end else begin
                e = exp_pop(d);
                check("word", d, 32'(cur), 32'(e));
            end
            obs_push(d, cur);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        rst_req = 1'b1;
        repeat (n) step();
        rst_req = 1'b0;
        obs_clear();
    endtask

    task automatic set_rem_all(input int n);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 8; k++) rem[d][k] = n;
    endtask

    task automatic snap_tot();
        for (int d = 0; d < 2; d++) begin
            tot[d] = 0;
            for (int k = 0; k < 8; k++) tot[d] += rem[d][k];
        end
    endtask

    function automatic bit idle();
        for (int d = 0; d < 2; d++) begin
            if (exp_size(d) > 0 || in_valid[d] != 8'd0 || out_valid[d] || pend[d] >= 0) return 1'b0;
            for (int k = 0; k < 8; k++) if (rem[d][k] > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain();
        p_valid = 100;
        p_ready = 100;
        for (int i = 0; i < 600; i++) begin
            if (idle()) break;
            step();
        end
        check("drain_idle", 0, 32'(idle()), 32'd1);
    endtask

    // Compare the observed out_sel order against a digit string.
    task automatic check_seq(input int d, input string s, input bit chk_data);
        logic [18:0] v;
        check($sformatf("seq_len>=%0d", s.len()), d, 32'(obs_size(d) >= s.len()), 32'd1);
        for (int i = 0; i < s.len() && i < obs_size(d); i++) begin
            v = obs_at(d, i);
            check($sformatf("seq[%0d].sel", i), d, 32'(v[18:16]), 32'(s[i] - "0"));
            if (chk_data) check($sformatf("seq[%0d].data", i), d, 32'(v[15:0]), 32'(16'hA0 + v[18:16]));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = '0; in_data[d] = '0; out_ready[d] = 1'b0;
            pend[d] = -1; m_ptr[d] = 0; m_own[d] = -1; m_cnt[d] = 0; m_ov[d] = 1'b0;
            held[d] = 1'b0;
        end
        set_rem_all(0);
        p_valid = 100; p_ready = 100; fixed_data = 1'b1;

        // Reset held two cycles with every channel valid, then full-rate round robin.
        set_rem_all(9);
        do_reset(2);
        run(14);
        check_seq(0, "012345670", 1'b1);
        check_seq(1, "000011112", 1'b1);
        if (obs0.size() >= 9) check("one_word_per_cycle", 0, 32'(obst0[8] - obst0[0]), 32'd8);
        drain();

        // Two contending channels: bursts of four versus strict alternation.
        set_rem_all(0);
        rem[0][2] = 12; rem[0][5] = 12; rem[1][2] = 12; rem[1][5] = 12;
        do_reset(1);
        run(18);
        check_seq(0, "252525252525", 1'b1);
        check_seq(1, "222255552222", 1'b1);
        drain();

        // Owner runs dry after two words: the burst ends early and ch4 takes over.
        set_rem_all(0);
        rem[0][3] = 2; rem[0][4] = 4; rem[1][3] = 2; rem[1][4] = 4;
        do_reset(1);
        run(12);
        check_seq(0, "343444", 1'b1);
        check_seq(1, "334444", 1'b1);
        drain();

        // Back-pressure: three stalled cycles mid-stream, nothing lost or duplicated.
        fixed_data = 1'b0;
        set_rem_all(10);
        snap_tot();
        do_reset(1);
        run(3);
        p_ready = 0;
        run(3);
        p_ready = 100;
        drain();
        check("word_count", 0, 32'(obs_size(0)), 32'(tot[0]));
        check("word_count", 1, 32'(obs_size(1)), 32'(tot[1]));

        // Random traffic and random back-pressure at several densities.
        for (int r = 0; r < 4; r++) begin
            fixed_data = 1'b0;
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 8; k++) rem[d][k] = $urandom_range(15);
            snap_tot();
            do_reset(1);
            p_valid = 30 + r * 20;
            p_ready = 40 + r * 15;
            run(300);
            drain();
            check("word_count", 0, 32'(obs_size(0)), 32'(tot[0]));
            check("word_count", 1, 32'(obs_size(1)), 32'(tot[1]));
        end

        // Reset while ch6 sits in the output register: pointer must restart at ch0.
        fixed_data = 1'b1;
        set_rem_all(0);
        rem[0][6] = 1; rem[1][6] = 1;
        p_valid = 100; p_ready = 0;
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            if (out_valid[0] && out_valid[1]) break;
            step();
        end
        check("pre_reset_valid", 0, 32'(out_valid[0]), 32'd1);
        check("pre_reset_sel", 0, 32'(out_sel[0]), 32'd6);
        check("pre_reset_sel", 1, 32'(out_sel[1]), 32'd6);
        set_rem_all(2);
        do_reset(1);
        p_ready = 100;
        run(4);
        check_seq(0, "0", 1'b1);
        check_seq(1, "0", 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
